// File: rtl/laser_channel_ctrl.sv
// laser_channel_ctrl: multi-cannon laser engine on the game-tick clock.
// Each channel launches a projectile on a fire-button rising edge, steps it
// toward its monster, reports hit/miss with one-tick pulses, then re-arms
// after a cooldown. With SINGLE_FIRE set, only the lowest idle requesting
// channel launches on a given tick.
// Optional feature macro: LASER_HIT_COUNT_EN adds per-channel 8-bit
// saturating hit counters on output hit_count.
module laser_channel_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned POS_W       = 11,
    parameter int unsigned START_POS   = 256,
    parameter int unsigned HIT_POS     = 76,
    parameter int unsigned STEP        = 2,
    parameter int unsigned COOLDOWN    = 8,
    parameter int unsigned SINGLE_FIRE = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_CH-1:0]         fire_req,
    input  logic [NUM_CH-1:0]         target_present,
    output logic [NUM_CH*POS_W-1:0]   laser_pos,
    output logic [NUM_CH-1:0]         shooting,
    output logic [NUM_CH-1:0]         hit_pulse,
    output logic [NUM_CH-1:0]         miss_pulse,
    output logic [NUM_CH-1:0]         target_kill
`ifdef LASER_HIT_COUNT_EN
    ,
    output logic [NUM_CH*8-1:0]       hit_count
`endif
);

    localparam int unsigned CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);
    localparam logic [POS_W-1:0] HIT_P   = POS_W'(HIT_POS);
    localparam logic [POS_W-1:0] STEP_P  = POS_W'(STEP);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_COOL   = 2'd2
    } state_t;

    logic [NUM_CH-1:0] r_fire_prev;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_grant;

    state_t            r_state     [NUM_CH];
    state_t            w_state_nxt [NUM_CH];
    logic [POS_W-1:0]  r_pos       [NUM_CH];
    logic [POS_W-1:0]  w_pos_nxt   [NUM_CH];
    logic [CD_W-1:0]   r_cd        [NUM_CH];
    logic [CD_W-1:0]   w_cd_nxt    [NUM_CH];

    logic [NUM_CH-1:0] r_hit;
    logic [NUM_CH-1:0] r_miss;
    logic [NUM_CH-1:0] r_shoot;
    logic [NUM_CH-1:0] w_hit_nxt;
    logic [NUM_CH-1:0] w_miss_nxt;
    logic [NUM_CH-1:0] w_shoot_nxt;

    // Previous fire level, so a held button produces exactly one edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fire_prev <= '0;
        end else begin
            r_fire_prev <= fire_req;
        end
    end

    assign w_edge = fire_req & ~r_fire_prev;

    // Launch arbitration: only idle channels may launch; optionally lowest index only
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_req[i] = w_edge[i] & (r_state[i] == ST_IDLE);
        end
        if (SINGLE_FIRE != 0) begin
            w_grant = w_req & (~w_req + NUM_CH'(1));
        end else begin
            w_grant = w_req;
        end
    end

    // Per-channel state, position, cooldown and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_pos[i]   <= START_P;
                r_cd[i]    <= '0;
            end
            r_hit   <= '0;
            r_miss  <= '0;
            r_shoot <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_pos[i]   <= w_pos_nxt[i];
                r_cd[i]    <= w_cd_nxt[i];
            end
            r_hit   <= w_hit_nxt;
            r_miss  <= w_miss_nxt;
            r_shoot <= w_shoot_nxt;
        end
    end

    // Next-state: hit check has priority over the out-of-range check
    always_comb begin
        w_hit_nxt   = '0;
        w_miss_nxt  = '0;
        w_shoot_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_pos_nxt[i]   = r_pos[i];
            w_cd_nxt[i]    = r_cd[i];

            case (r_state[i])
                ST_IDLE: begin
                    if (w_grant[i]) begin
                        w_state_nxt[i] = ST_FLIGHT;
                        w_pos_nxt[i]   = START_P;
                    end
                end
                ST_FLIGHT: begin
                    if (target_present[i] && (r_pos[i] <= HIT_P)) begin
                        w_hit_nxt[i] = 1'b1;
                        w_pos_nxt[i] = START_P;
                        w_cd_nxt[i]  = CD_LOAD;
                        w_state_nxt[i] = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
                    end else if (r_pos[i] < STEP_P) begin
                        w_miss_nxt[i] = 1'b1;
                        w_pos_nxt[i]  = START_P;
                        w_cd_nxt[i]   = CD_LOAD;
                        w_state_nxt[i] = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
                    end else begin
                        w_pos_nxt[i] = r_pos[i] - STEP_P;
                    end
                end
                ST_COOL: begin
                    if ((r_cd[i] == CD_ONE) || (r_cd[i] == '0)) begin
                        w_cd_nxt[i]    = '0;
                        w_state_nxt[i] = ST_IDLE;
                    end else begin
                        w_cd_nxt[i] = r_cd[i] - CD_ONE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_pos_nxt[i]   = START_P;
                    w_cd_nxt[i]    = '0;
                end
            endcase

            w_shoot_nxt[i] = (w_state_nxt[i] == ST_FLIGHT);
        end
    end

    // Pack per-channel positions onto the renderer bus
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
        assign laser_pos[g*POS_W +: POS_W] = r_pos[g];
    end

    assign shooting    = r_shoot;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign target_kill = r_hit;

`ifdef LASER_HIT_COUNT_EN
    logic [7:0] r_hit_cnt [NUM_CH];

    // Saturating per-channel hit counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_hit_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_hit[i] && (r_hit_cnt[i] != 8'hFF)) begin
                    r_hit_cnt[i] <= r_hit_cnt[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign hit_count[g*8 +: 8] = r_hit_cnt[g];
    end
`endif

endmodule

// File: doc/laser_channel_ctrl.md
Name: laser_channel_ctrl

Overview:
Multi-channel laser engine for the starship game. It generalises the single top-cannon shooter to NUM_CH independent cannons (0=top, 1=bottom, 2=left, 3=right by default), each with its own projectile position, flight state, hit detection against its monster, and re-arm cooldown. It runs on the slow game-tick clock between button debouncing and the VGA renderer, which draws bullets from laser_pos.

Parameters:
NUM_CH, 4, number of cannon channels (1..8)
POS_W, 11, width of each projectile position counter
START_POS, 256, position loaded at reset and after every shot ends
HIT_POS, 76, position at or below which a present target is hit
STEP, 2, position decrement per tick in flight (1..START_POS)
COOLDOWN, 8, idle ticks after a shot before the channel re-arms (0 = none)
SINGLE_FIRE, 1, 1 = at most one launch per tick, lowest index wins; 0 = all channels launch independently

Ports:
Clk  in  1  game tick clock
Reset  in  1  asynchronous, active-high
fire_req  in  NUM_CH  per-channel fire button, level
target_present  in  NUM_CH  per-channel monster currently displayed
laser_pos  out  NUM_CH*POS_W  packed positions, channel i at [i*POS_W +: POS_W]
shooting  out  NUM_CH  channel in FLIGHT
hit_pulse  out  NUM_CH  one-tick pulse when a channel hits its target
miss_pulse  out  NUM_CH  one-tick pulse when a shot leaves range without a hit
target_kill  out  NUM_CH  one-tick pulse telling the monster controller to remove target i; identical timing to hit_pulse

Behaviour:
- Reset (async): every channel IDLE, laser_pos=START_POS, shooting=0, all pulses 0, cooldown counters 0, fire_req edge registers 0.
- Fire detection is rising-edge only: fire_prev registered each tick; edge_i = fire_req[i] & ~fire_prev[i]. A held button never re-fires.
- Per-channel FSM: IDLE, FLIGHT, COOLDOWN.
- IDLE: if edge_i and the channel is granted -> FLIGHT next tick, pos stays START_POS. An edge arriving in FLIGHT or COOLDOWN is discarded, not queued.
- Grant: SINGLE_FIRE=1 -> among channels that are IDLE with edge, only the lowest index launches; the others' edges are dropped. SINGLE_FIRE=0 -> every IDLE channel with an edge launches.
- FLIGHT: shooting=1. Each tick evaluates the current pos in this priority order:
  - target_present[i] && pos<=HIT_POS -> hit_pulse/target_kill high next tick for exactly one tick, pos<=START_POS, go to COOLDOWN.
  - else pos<STEP -> miss_pulse for one tick, pos<=START_POS, go to COOLDOWN. No underflow ever occurs.
  - else pos<=pos-STEP.
- The hit test uses <= so odd STEP or late target appearance cannot skip the hit window. A target appearing when pos is already below HIT_POS is still hit.
- COOLDOWN: counter loads COOLDOWN on entry and decrements each tick; reaches 0 -> IDLE. With COOLDOWN=0, FLIGHT exits directly to IDLE.
- Pulses are registered and never overlap on the same channel. Channels are fully independent except for the SINGLE_FIRE grant.
- Reset mid-flight aborts all shots with no pulses.
- Latency with defaults: edge seen at tick T gives FLIGHT from T+1. A hit with target present throughout is evaluated at tick T+91 (pos=76), pulses during T+92. A miss with no target evaluates pos=0 at T+129.

Optional Feature:
LASER_HIT_COUNT_EN. When defined, adds output hit_count (NUM_CH*8), one 8-bit saturating counter per channel. Each counter increments on that channel's hit_pulse, holds at 255, and clears on Reset. When undefined, the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then fire_req[0] rising with target_present[0]=1 held -> shooting[0]=1 one tick later; laser_pos[0] steps 256,254,...,76; hit_pulse[0] and target_kill[0] for one tick; laser_pos[0]=256; shooting[0]=0 for 8 ticks, then re-armed.
- fire_req[1] with target_present[1]=0 -> pos reaches 0, miss_pulse[1] one tick, no target_kill, pos=256.
- SINGLE_FIRE=1, fire_req[2] and fire_req[3] rising on the same tick -> only channel 2 flies; channel 3 stays IDLE with no launch until a new edge arrives.
- Holding fire_req[0] high across a full shot and its cooldown -> exactly one shot; second press during FLIGHT is ignored.
- Assert Reset when laser_pos[0]=150 mid-flight -> immediately pos=256, shooting=0, no pulses.
- LASER_HIT_COUNT_EN defined, 3 hits on channel 0 -> hit_count[7:0]=3; force 260 hits -> saturates at 255.
